alu_result_serializer: RTL and testbench



---
 rtl/alu_result_serializer_pkg.sv | 21 ++
 rtl/alu_result_serializer_if.sv | 30 +++
 rtl/alu_result_serializer_sync_fifo.sv | 54 +++++
 rtl/alu_result_serializer.sv | 79 +++++++
 tb/tb_alu_result_serializer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_serializer_pkg.sv
// Shared types for the ALU result serializer: op codes, FIFO entry layout
// and the beat-state encoding of the output FSM.
package alu_pkg;

  localparam int RESULT_W = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef struct packed {
    logic                op;
    logic                carry;
    logic [RESULT_W-1:0] result;
  } alu_entry_t;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } beat_state_t;

endpackage

// File: rtl/alu_result_serializer_if.sv
// Bus bundle between the ALU, the serializer and the 32-bit consumer.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface alu_result_serializer_if #(
    parameter int DEPTH  = 2,
    parameter int WORD_W = 32
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_result;
    logic              in_carry;
    logic              in_op;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_carry;
    logic              out_last;
    logic [LVL_W-1:0]  level;

    modport slave (
        input  in_valid, in_result, in_carry, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_last, level
    );

    modport master (
        output in_valid, in_result, in_carry, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_last, level
    );
endinterface

// File: rtl/alu_result_serializer_sync_fifo.sv
// Single-clock FIFO with power-of-2 depth; pointers wrap naturally.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [LVL_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rptr];
    assign level   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (pop_ok)  rptr <= rptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end
endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and emits them as WORD_W beats: one beat for an add,
// low then high word for a multiply.
module alu_result_serializer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int WORD_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_result_serializer_if.slave  bus,
    output beat_state_t             beat_state
);
    alu_entry_t  wr_entry;
    alu_entry_t  head;
    logic        full;
    logic        empty;
    logic        push;
    logic        fire;
    logic        pop;
    logic [WORD_W-1:0] data_mux;
    logic        carry_mux;
    logic        last_mux;

    assign wr_entry = '{op: bus.in_op, carry: bus.in_carry, result: bus.in_result};

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push = bus.in_valid && !full;
    assign fire = !empty && bus.out_ready;
    // An entry leaves only after its final beat is accepted.
    assign pop  = fire && ((beat_state == S_HI) || (head.op == OP_ADD));

    sync_fifo #(
        .WIDTH ($bits(alu_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (bus.level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_state <= S_LO;
        end else if (fire) begin
            if ((beat_state == S_LO) && (head.op == OP_MUL)) beat_state <= S_HI;
            else                                             beat_state <= S_LO;
        end
    end

    always_comb begin
        data_mux  = '0;
        carry_mux = 1'b0;
        last_mux  = 1'b0;
        if (!empty) begin
            if (beat_state == S_HI) begin
                data_mux = head.result[2*WORD_W-1:WORD_W];
                last_mux = 1'b1;
            end else begin
                data_mux = head.result[WORD_W-1:0];
                if (head.op == OP_ADD) begin
                    carry_mux = head.carry;
                    last_mux  = 1'b1;
                end
            end
        end
    end

    assign bus.out_data  = data_mux;
    assign bus.out_carry = carry_mux;
    assign bus.out_last  = last_mux;
endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: expected beats are queued when an
// entry is accepted and compared in order as the consumer accepts them.
module tb_alu_result_serializer;
    import alu_pkg::*;

    localparam int DEPTH  = 2;
    localparam int WORD_W = 32;
    localparam int BEAT_W = WORD_W + 2;

    logic        clk;
    logic        rst;
    beat_state_t beat_state;
    logic        rand_ready;
    int          n_checks;
    int          n_fail;
    logic [BEAT_W-1:0] exp_q[$];

    alu_result_serializer_if #(.DEPTH(DEPTH), .WORD_W(WORD_W)) bus ();

    alu_result_serializer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .beat_state (beat_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 1) != 0);
    endtask

    task automatic send(input logic op, input logic carry, input logic [63:0] result);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_carry  = carry;
        bus.in_result = result;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 64'(bus.in_ready), 64'd1);
        end else if (op == OP_ADD) begin
            exp_q.push_back({result[WORD_W-1:0], carry, 1'b1});
        end else begin
            exp_q.push_back({result[WORD_W-1:0], 1'b0, 1'b0});
            exp_q.push_back({result[2*WORD_W-1:WORD_W], 1'b0, 1'b1});
        end
        step();
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'($urandom_range(0, 1));
        bus.in_carry  = 1'($urandom_range(0, 1));
        bus.in_result = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.level != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        check("drain_level", 64'(bus.level), 64'd0);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard
    always @(negedge clk) begin : mon
        logic [BEAT_W-1:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'({bus.out_data, bus.out_carry, bus.out_last}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", 64'({bus.out_data, bus.out_carry, bus.out_last}), 64'(e));
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rand_ready    = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'b0;
        bus.in_carry  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_level", 64'(bus.level), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_last", 64'({bus.out_carry, bus.out_last}), 64'd0);

        // 1: single add
        bus.out_ready = 1'b1;
        send(OP_ADD, 1'b1, 64'h0000_0000_FFFF_FFFF);
        check("t1_out_valid", 64'(bus.out_valid), 64'd1);
        check("t1_out_data", 64'(bus.out_data), 64'hFFFF_FFFF);
        check("t1_out_carry", 64'(bus.out_carry), 64'd1);
        check("t1_out_last", 64'(bus.out_last), 64'd1);
        step();
        check("t1_level_after", 64'(bus.level), 64'd0);

        // 2: multiply, two beats
        send(OP_MUL, 1'b1, 64'h1234_5678_9ABC_DEF0);
        check("t2_lo_data", 64'(bus.out_data), 64'h9ABC_DEF0);
        check("t2_lo_carry_last", 64'({bus.out_carry, bus.out_last}), 64'd0);
        step();
        check("t2_hi_data", 64'(bus.out_data), 64'h1234_5678);
        check("t2_hi_carry_last", 64'({bus.out_carry, bus.out_last}), 64'd1);
        step();
        check("t2_level_after", 64'(bus.level), 64'd0);

        // 3: fill with the consumer stalled, third push held off
        bus.out_ready = 1'b0;
        send(OP_ADD, 1'b0, 64'h0000_0000_0000_0011);
        send(OP_ADD, 1'b1, 64'hDEAD_0000_0000_0022);
        check("t3_level_full", 64'(bus.level), 64'd2);
        check("t3_in_ready_full", 64'(bus.in_ready), 64'd0);
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_ADD;
        bus.in_carry  = 1'b0;
        bus.in_result = 64'h0000_0000_0000_0033;
        step();
        check("t3_stalled_level", 64'(bus.level), 64'd2);
        bus.out_ready = 1'b1;
        check("t3_in_ready_full_pop", 64'(bus.in_ready), 64'd0);
        step();
        check("t3_level_after_pop", 64'(bus.level), 64'd1);
        check("t3_in_ready_after_pop", 64'(bus.in_ready), 64'd1);
        exp_q.push_back({32'h0000_0033, 1'b0, 1'b1});
        step();
        bus.in_valid = 1'b0;
        check("t3_level_push_pop", 64'(bus.level), 64'd1);
        drain();

        // 4: stall on the high beat of a multiply
        bus.out_ready = 1'b0;
        send(OP_MUL, 1'b0, 64'h1234_5678_9ABC_DEF0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_hi_data", 64'(bus.out_data), 64'h1234_5678);
            check("t4_hi_last", 64'(bus.out_last), 64'd1);
            check("t4_level", 64'(bus.level), 64'd1);
            check("t4_state", 64'(beat_state), 64'(S_HI));
            step();
        end
        drain();

        // 5: mixed adds/muls with a randomly stalling consumer across pointer wrap
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end
        drain();

        // 6: asynchronous reset between the two beats of a multiply
        bus.out_ready = 1'b0;
        send(OP_MUL, 1'b0, 64'hCAFE_F00D_0BAD_BEEF);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("t6_pre_state", 64'(beat_state), 64'(S_HI));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_level", 64'(bus.level), 64'd0);
        check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("t6_rst_out_data", 64'(bus.out_data), 64'd0);
        check("t6_rst_state", 64'(beat_state), 64'(S_LO));
        exp_q.delete();
        #2 rst = 1'b0;
        step();
        send(OP_MUL, 1'b0, 64'h0000_0001_0000_0002);
        check("t6_post_lo_data", 64'(bus.out_data), 64'h0000_0002);
        check("t6_post_lo_last", 64'(bus.out_last), 64'd0);
        check("t6_post_level", 64'(bus.level), 64'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
